pipe_ctrl_gen: RTL and testbench
================================

Name: pipe_ctrl_gen

Overview:
Parametrised pipeline control unit for the 5-stage core. It merges per-stage stall requests into a prefix stall vector and inserts bubbles at the stall boundary. It adds a multi-cycle-unit (mult/div) wait FSM with timeout, a single-cycle exception/eret flush with redirect PC, and saturating performance counters. Sits beside IF/ID/EX/MEM/WB and drives their StallBus-style stall inputs; it is not a pure tie-off.

Parameters:
NSTAGE, 6, stall vector width; bit0 = PC, bit1 = IF, bit2 = ID, bit3 = EX, bit4 = MEM, bit5 = WB
EX_IDX, 3, stage index that owns the multi-cycle unit
MC_TIMEOUT, 64, maximum MC_WAIT cycles before abort; must be ≥2
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
stallreq  in  NSTAGE  per-stage stall request; bit i from stage i
flush_req  in  1  exception/eret flush request from MEM
flush_pc_in  in  32  redirect target accompanying flush_req
mc_start  in  1  EX launches a multi-cycle operation
mc_done  in  1  multi-cycle result valid
stall  out  NSTAGE  stage hold vector
bubble  out  NSTAGE  bit i: load NOP into stage i's input register
flush  out  1  clear all pipeline registers this cycle
new_pc  out  32  redirect PC, valid when flush=1
mc_busy  out  1  FSM in MC_WAIT
mc_abort  out  1  one-cycle pulse: multi-cycle op cancelled by flush or timeout
mc_timeout  out  1  one-cycle pulse: timeout occurred
stall_cycles  out  CNT_W  cycles with any stall bit set, saturating
flush_count  out  CNT_W  number of flushes, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, timeout counter=0, stall_cycles=0, flush_count=0, mc_abort=0, mc_timeout=0. While rst=0, stall, bubble, flush, new_pc and mc_busy read 0.
- Effective request: eff = stallreq, OR'd with bit EX_IDX while mc_wait_active. mc_wait_active = (state==MC_WAIT and not mc_done) or (state==IDLE and mc_start and not mc_done).
- stall and bubble are combinational from eff, state and inputs, with zero latency.
- Let k be the highest set bit of eff. Then stall[j]=1 for all j≤k, and stall[j]=0 for j>k.
- bubble[k+1]=1 if k+1<NSTAGE; all other bubble bits are 0. eff=0 gives stall=0 and bubble=0.
- Flush dominates: when flush_req=1, stall=0, bubble=0, flush=1 and new_pc=flush_pc_in in the same cycle. Otherwise flush=0 and new_pc=0.
- FSM states: IDLE, MC_WAIT.
  - IDLE→MC_WAIT: mc_start=1, mc_done=0, flush_req=0. The timeout counter loads 1.
  - IDLE with mc_start=mc_done=1: single-cycle completion. No stall is contributed and the FSM stays in IDLE.
  - MC_WAIT→IDLE on mc_done=1. The EX stall is released in that same cycle so EX captures the result.
  - MC_WAIT→IDLE on flush_req=1. mc_abort pulses in the next cycle (registered). mc_done in the same cycle is ignored.
  - MC_WAIT with counter==MC_TIMEOUT and no mc_done: go to IDLE, and mc_abort and mc_timeout pulse next cycle. The EX stall drops on the following cycle.
  - Otherwise the counter increments each cycle.
  - mc_start while in MC_WAIT is ignored (protocol violation; no state change).
  - flush_req in IDLE together with mc_start: the operation is not started and no mc_abort pulse is generated.
- mc_busy = (state==MC_WAIT).
- Counters: stall_cycles increments on any cycle where the stall output is nonzero. flush_count increments on any cycle with flush_req=1. Both saturate at 2^CNT_W−1 and never wrap.
- Reset mid-operation: MC_WAIT is abandoned immediately, with no mc_abort pulse, and all outputs go to their reset values.

Test Plan:
- NSTAGE=6, stallreq=6'b000100 (ID) → stall=6'b000111, bubble=6'b001000. Then stallreq=0 → stall=0, bubble=0, stall_cycles=1.
- stallreq=6'b010010 (MEM and IF together) → stall=6'b011111, bubble=6'b100000.
- mc_start at cycle 0, mc_done at cycle 5 → stall=6'b001111 on cycles 0–4 and stall=0 on cycle 5. mc_busy=1 on cycles 1–5. stall_cycles=5, mc_abort never pulses.
- MC_WAIT entered, flush_req=1 with flush_pc_in=32'hBFC00380 on cycle 3 → on cycle 3 flush=1, new_pc=32'hBFC00380, stall=0. On cycle 4 mc_abort=1, mc_busy=0, flush_count=1.
- MC_TIMEOUT=4, mc_start with mc_done held 0 → mc_busy for 4 cycles, then IDLE. mc_abort=mc_timeout=1 for exactly one cycle.
- rst driven low asynchronously in mid-MC_WAIT while stallreq=6'b111111 → stall=0, mc_busy=0 and counters=0 immediately, with no clock edge required. After release, state is IDLE.

Source files
------------

// File: rtl/pipe_ctrl_gen.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_gen
// Pipeline control unit for the 5-stage core. It folds the per-stage stall
// requests (plus the EX stall held while a multi-cycle mult/div is running)
// into a prefix hold vector, and it marks the stage just after the stall
// boundary for a bubble. It also owns the multi-cycle wait FSM with timeout,
// the exception/eret flush with its redirect PC, and two saturating
// performance counters.
//
// Stall vector bit order: bit0 = PC, bit1 = IF, bit2 = ID, bit3 = EX,
// bit4 = MEM, bit5 = WB (for NSTAGE = 6). Stalling stage k freezes every
// upstream stage j <= k; stage k+1 is fed a NOP so that it does not
// re-execute what it already holds.
// ---------------------------------------------------------------------------
module pipe_ctrl_gen #(
    parameter int NSTAGE     = 6,
    parameter int EX_IDX     = 3,
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,           // asynchronous, active-low
    input  logic [NSTAGE-1:0] stallreq,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc_in,
    input  logic              mc_start,
    input  logic              mc_done,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] bubble,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              mc_busy,
    output logic              mc_abort,
    output logic              mc_timeout,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    // -----------------------------------------------------------------------
    // Local constants and types
    // -----------------------------------------------------------------------
    // The timeout counter must be able to hold MC_TIMEOUT itself.
    localparam int               TMO_W    = $clog2(MC_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MC_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MC_WAIT = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Registers and internal nets
    // -----------------------------------------------------------------------
    state_t             r_state;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_mc_abort;
    logic               r_mc_timeout;
    logic [CNT_W-1:0]   r_stall_cycles;
    logic [CNT_W-1:0]   r_flush_count;

    state_t             w_state_nxt;
    logic [TMO_W-1:0]   w_tmo_cnt_nxt;
    logic               w_abort_nxt;
    logic               w_timeout_nxt;

    logic               w_mc_wait_active;
    logic [NSTAGE-1:0]  w_eff;
    logic [NSTAGE-1:0]  w_stall;
    logic [NSTAGE-1:0]  w_bubble;
    logic               w_acc;
    logic               w_flush;

    // -----------------------------------------------------------------------
    // Effective stall request: the stage requests plus the EX hold while a
    // multi-cycle op is outstanding. A start in IDLE stalls EX from its very
    // first cycle; mc_done releases EX in the same cycle so it captures the
    // result. A start that completes in the same cycle contributes nothing.
    // -----------------------------------------------------------------------
    // Merge stage requests with the multi-cycle EX hold.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_mc_wait_active = 1'b0;
        w_eff            = stallreq;
        if (!mc_done) begin
            w_mc_wait_active = (r_state == ST_MC_WAIT) ||
                               ((r_state == ST_IDLE) && mc_start);
        end
        if (w_mc_wait_active) begin
            w_eff[EX_IDX] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Prefix hold vector and bubble. Scanning from the WB end downward, once
    // any request is seen every lower stage must hold too. The bubble goes
    // to the first stage above the boundary, i.e. the bit where the hold
    // vector steps from 1 to 0; a stall of the top stage has no bubble.
    // A flush or an asserted reset forces both vectors to zero.
    // -----------------------------------------------------------------------
    // Build the prefix stall vector and the single bubble bit.
    always_comb begin
        w_acc   = 1'b0;
        w_stall = '0;
        for (int j = NSTAGE - 1; j >= 0; j--) begin
            w_acc      = w_acc | w_eff[j];
            w_stall[j] = w_acc;
        end
        if (flush_req || !rst) begin
            w_stall = '0;
        end
        w_bubble = (w_stall << 1) & ~w_stall;
    end

    // Flush is a pure pass-through of the request, silenced during reset.
    assign w_flush = flush_req & rst;

    // -----------------------------------------------------------------------
    // Multi-cycle wait FSM. Flush has top priority in MC_WAIT (a same-cycle
    // mc_done is discarded because the instruction is being squashed), then
    // completion, then timeout. Abort/timeout are registered single-cycle
    // pulses raised on the edge that leaves MC_WAIT.
    // -----------------------------------------------------------------------
    // State register, timeout counter and registered pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_tmo_cnt    <= '0;
            r_mc_abort   <= 1'b0;
            r_mc_timeout <= 1'b0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples the pre-edge values of the others.
            r_state      <= w_state_nxt;
            r_tmo_cnt    <= w_tmo_cnt_nxt;
            r_mc_abort   <= w_abort_nxt;
            r_mc_timeout <= w_timeout_nxt;
        end
    end

    // Next-state, timeout counter and pulse decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_tmo_cnt_nxt = r_tmo_cnt;
        w_abort_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A flush in the same cycle squashes the launching
                // instruction, so the op never starts and nothing aborts.
                if (mc_start && !mc_done && !flush_req) begin
                    w_state_nxt   = ST_MC_WAIT;
                    w_tmo_cnt_nxt = TMO_ONE;
                end
            end
            ST_MC_WAIT: begin
                // mc_start here is a protocol violation and is ignored.
                if (flush_req) begin
                    w_state_nxt   = ST_IDLE;
                    w_tmo_cnt_nxt = '0;
                    w_abort_nxt   = 1'b1;
                end else if (mc_done) begin
                    w_state_nxt   = ST_IDLE;
                    w_tmo_cnt_nxt = '0;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_tmo_cnt_nxt = '0;
                    w_abort_nxt   = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + TMO_ONE;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_tmo_cnt_nxt = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Performance counters. stall_cycles follows the stall output actually
    // presented to the pipe (so a flush-suppressed request is not counted);
    // flush_count follows flush requests. Both stick at all-ones.
    // -----------------------------------------------------------------------
    // Saturating stall-cycle and flush counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if ((|w_stall) && (r_stall_cycles != CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end
            if (flush_req && (r_flush_count != CNT_MAX)) begin
                r_flush_count <= r_flush_count + CNT_ONE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign stall        = w_stall;
    assign bubble       = w_bubble;
    assign flush        = w_flush;
    assign new_pc       = w_flush ? flush_pc_in : 32'h0000_0000;
    assign mc_busy      = (r_state == ST_MC_WAIT);
    assign mc_abort     = r_mc_abort;
    assign mc_timeout   = r_mc_timeout;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_gen
// Two instances share one stimulus: dut_a (MC_TIMEOUT=8, CNT_W=32) covers
// the long multi-cycle op and flush cases, dut_b (MC_TIMEOUT=4, CNT_W=3)
// covers timeout and counter saturation. Expected per-cycle outputs are
// pushed to a scoreboard queue as stimulus is driven and popped when the
// selected instance's outputs are sampled, before the next rising edge.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_gen;

    localparam int NST = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [NST-1:0]  stallreq;
    logic            flush_req;
    logic [31:0]     flush_pc_in;
    logic            mc_start;
    logic            mc_done;

    logic [NST-1:0]  a_stall, a_bubble, b_stall, b_bubble;
    logic            a_flush, a_busy, a_abort, a_tmo;
    logic            b_flush, b_busy, b_abort, b_tmo;
    logic [31:0]     a_new_pc, b_new_pc;
    logic [31:0]     a_sc, a_fc;
    logic [2:0]      b_sc, b_fc;

    pipe_ctrl_gen #(.NSTAGE(NST), .EX_IDX(3), .MC_TIMEOUT(8), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
        .flush_pc_in(flush_pc_in), .mc_start(mc_start), .mc_done(mc_done),
        .stall(a_stall), .bubble(a_bubble), .flush(a_flush), .new_pc(a_new_pc),
        .mc_busy(a_busy), .mc_abort(a_abort), .mc_timeout(a_tmo),
        .stall_cycles(a_sc), .flush_count(a_fc)
    );

    pipe_ctrl_gen #(.NSTAGE(NST), .EX_IDX(3), .MC_TIMEOUT(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
        .flush_pc_in(flush_pc_in), .mc_start(mc_start), .mc_done(mc_done),
        .stall(b_stall), .bubble(b_bubble), .flush(b_flush), .new_pc(b_new_pc),
        .mc_busy(b_busy), .mc_abort(b_abort), .mc_timeout(b_tmo),
        .stall_cycles(b_sc), .flush_count(b_fc)
    );

    // Observed outputs of whichever instance the current test targets.
    logic            use_b;
    logic [NST-1:0]  o_stall, o_bubble;
    logic            o_flush, o_busy, o_abort, o_tmo;
    logic [31:0]     o_new_pc, o_sc, o_fc;

    always_comb begin
        if (use_b) begin
            o_stall = b_stall;  o_bubble = b_bubble; o_flush = b_flush;
            o_new_pc = b_new_pc; o_busy = b_busy; o_abort = b_abort; o_tmo = b_tmo;
            o_sc = {29'd0, b_sc}; o_fc = {29'd0, b_fc};
        end else begin
            o_stall = a_stall;  o_bubble = a_bubble; o_flush = a_flush;
            o_new_pc = a_new_pc; o_busy = a_busy; o_abort = a_abort; o_tmo = a_tmo;
            o_sc = a_sc; o_fc = a_fc;
        end
    end

    typedef struct {
        string          tag;
        logic [NST-1:0] stall;
        logic [NST-1:0] bubble;
        logic           flush;
        logic [31:0]    new_pc;
        logic           busy;
        logic           abort;
        logic           tmo;
        logic [31:0]    sc;
        logic [31:0]    fc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_sc, exp_fc, cnt_max;

    // Pop one expected entry and compare it with the sampled outputs.
    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        e = sb_q.pop_front();
        n_cmp++; if (o_stall !== e.stall) begin n_bad++;
            $display("FAIL %s stall: got %b expected %b", e.tag, o_stall, e.stall); end
        n_cmp++; if (o_bubble !== e.bubble) begin n_bad++;
            $display("FAIL %s bubble: got %b expected %b", e.tag, o_bubble, e.bubble); end
        n_cmp++; if (o_flush !== e.flush) begin n_bad++;
            $display("FAIL %s flush: got %b expected %b", e.tag, o_flush, e.flush); end
        n_cmp++; if (o_new_pc !== e.new_pc) begin n_bad++;
            $display("FAIL %s new_pc: got %h expected %h", e.tag, o_new_pc, e.new_pc); end
        n_cmp++; if (o_busy !== e.busy) begin n_bad++;
            $display("FAIL %s mc_busy: got %b expected %b", e.tag, o_busy, e.busy); end
        n_cmp++; if (o_abort !== e.abort) begin n_bad++;
            $display("FAIL %s mc_abort: got %b expected %b", e.tag, o_abort, e.abort); end
        n_cmp++; if (o_tmo !== e.tmo) begin n_bad++;
            $display("FAIL %s mc_timeout: got %b expected %b", e.tag, o_tmo, e.tmo); end
        n_cmp++; if (o_sc !== e.sc) begin n_bad++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", e.tag, o_sc, e.sc); end
        n_cmp++; if (o_fc !== e.fc) begin n_bad++;
            $display("FAIL %s flush_count: got %0d expected %0d", e.tag, o_fc, e.fc); end
    endtask

    task automatic drive(input logic [NST-1:0] sr, input logic fr, input logic [31:0] pc,
                         input logic st, input logic dn);
        stallreq = sr; flush_req = fr; flush_pc_in = pc; mc_start = st; mc_done = dn;
    endtask

    // One clock cycle: drive inputs, push expectation, sample, compare.
    task automatic step(input string tag, input logic [NST-1:0] sr, input logic fr,
                        input logic [31:0] pc, input logic st, input logic dn,
                        input logic [NST-1:0] x_stall, input logic [NST-1:0] x_bubble,
                        input logic x_busy, input logic x_abort, input logic x_tmo);
        exp_t e;
        @(negedge clk);
        drive(sr, fr, pc, st, dn);
        e.tag = tag; e.stall = x_stall; e.bubble = x_bubble;
        e.flush = fr; e.new_pc = fr ? pc : 32'h0;
        e.busy = x_busy; e.abort = x_abort; e.tmo = x_tmo;
        e.sc = exp_sc; e.fc = exp_fc;
        sb_q.push_back(e);
        #1;
        sb_check();
        if ((x_stall != '0) && (exp_sc < cnt_max)) exp_sc = exp_sc + 1;
        if (fr && (exp_fc < cnt_max)) exp_fc = exp_fc + 1;
    endtask

    task automatic do_reset(input logic sel_b);
        use_b = sel_b;
        cnt_max = sel_b ? 32'd7 : 32'hFFFF_FFFF;
        rst = 1'b0;
        drive('0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_sc = 0; exp_fc = 0;
    endtask

    task automatic test_reset();
        use_b = 1'b0;
        rst = 1'b0;
        drive(6'b111111, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        #1;
        n_cmp++; if (a_stall !== 6'b0) begin n_bad++; $display("FAIL rst_stall: got %b expected 000000", a_stall); end
        n_cmp++; if (a_bubble !== 6'b0) begin n_bad++; $display("FAIL rst_bubble: got %b expected 000000", a_bubble); end
        n_cmp++; if (a_flush !== 1'b0) begin n_bad++; $display("FAIL rst_flush: got %b expected 0", a_flush); end
        n_cmp++; if (a_new_pc !== 32'h0) begin n_bad++; $display("FAIL rst_new_pc: got %h expected 0", a_new_pc); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", a_busy); end
        n_cmp++; if ({a_abort, a_tmo} !== 2'b00) begin n_bad++; $display("FAIL rst_pulses: got %b expected 00", {a_abort, a_tmo}); end
        n_cmp++; if (a_sc !== 32'd0) begin n_bad++; $display("FAIL rst_stall_cycles: got %0d expected 0", a_sc); end
        n_cmp++; if (a_fc !== 32'd0) begin n_bad++; $display("FAIL rst_flush_count: got %0d expected 0", a_fc); end
        n_cmp++; if (b_fc !== 3'd0) begin n_bad++; $display("FAIL rst_flush_count_b: got %0d expected 0", b_fc); end
    endtask

    task automatic test_prefix();
        do_reset(1'b0);
        step("pfx_id",     6'b000100, 0, 0, 0, 0, 6'b000111, 6'b001000, 0, 0, 0);
        step("pfx_none",   6'b000000, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0);
        step("pfx_mem_if", 6'b010010, 0, 0, 0, 0, 6'b011111, 6'b100000, 0, 0, 0);
        step("pfx_wb",     6'b100000, 0, 0, 0, 0, 6'b111111, 6'b000000, 0, 0, 0);
        step("pfx_pc",     6'b000001, 0, 0, 0, 0, 6'b000001, 6'b000010, 0, 0, 0);
        step("pfx_end",    6'b000000, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0);
    endtask

    task automatic test_mc_done();
        do_reset(1'b0);
        step("mc_c0",   6'b000000, 0, 0, 1, 0, 6'b001111, 6'b010000, 0, 0, 0);
        step("mc_c1",   6'b000000, 0, 0, 0, 0, 6'b001111, 6'b010000, 1, 0, 0);
        step("mc_c2",   6'b000000, 0, 0, 1, 0, 6'b001111, 6'b010000, 1, 0, 0);
        step("mc_c3",   6'b010000, 0, 0, 0, 0, 6'b011111, 6'b100000, 1, 0, 0);
        step("mc_c4",   6'b000000, 0, 0, 0, 0, 6'b001111, 6'b010000, 1, 0, 0);
        step("mc_c5",   6'b000000, 0, 0, 0, 1, 6'b000000, 6'b000000, 1, 0, 0);
        step("mc_c6",   6'b000000, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0);
        step("mc_one",  6'b000000, 0, 0, 1, 1, 6'b000000, 6'b000000, 0, 0, 0);
        step("mc_idle", 6'b000000, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0);
    endtask

    task automatic test_flush();
        do_reset(1'b0);
        step("fl_c0",   6'b000000, 0, 32'h0,         1, 0, 6'b001111, 6'b010000, 0, 0, 0);
        step("fl_c1",   6'b000000, 0, 32'h0,         0, 0, 6'b001111, 6'b010000, 1, 0, 0);
        step("fl_c2",   6'b000000, 0, 32'h0,         0, 0, 6'b001111, 6'b010000, 1, 0, 0);
        step("fl_c3",   6'b000000, 1, 32'hBFC0_0380, 0, 1, 6'b000000, 6'b000000, 1, 0, 0);
        step("fl_c4",   6'b000000, 0, 32'h0,         0, 0, 6'b000000, 6'b000000, 0, 1, 0);
        step("fl_c5",   6'b000000, 0, 32'h0,         0, 0, 6'b000000, 6'b000000, 0, 0, 0);
        step("fl_start",6'b000000, 1, 32'h8000_0180, 1, 0, 6'b000000, 6'b000000, 0, 0, 0);
        step("fl_noab", 6'b000000, 0, 32'h0,         0, 0, 6'b000000, 6'b000000, 0, 0, 0);
        step("fl_dom",  6'b000010, 1, 32'h0000_1234, 0, 0, 6'b000000, 6'b000000, 0, 0, 0);
        step("fl_end",  6'b000000, 0, 32'h0,         0, 0, 6'b000000, 6'b000000, 0, 0, 0);
    endtask

    task automatic test_timeout();
        do_reset(1'b1);
        step("to_c0", 6'b000000, 0, 0, 1, 0, 6'b001111, 6'b010000, 0, 0, 0);
        for (int i = 1; i <= 4; i++)
            step($sformatf("to_c%0d", i), 6'b000000, 0, 0, 0, 0, 6'b001111, 6'b010000, 1, 0, 0);
        step("to_c5", 6'b000000, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 1, 1);
        step("to_c6", 6'b000000, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0);
    endtask

    task automatic test_saturation();
        do_reset(1'b1);
        for (int i = 0; i < 9; i++)
            step($sformatf("sat_fl%0d", i), 6'b000001, 1, 32'(i), 0, 0, 6'b000000, 6'b000000, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            step($sformatf("sat_st%0d", i), 6'b000001, 0, 0, 0, 0, 6'b000001, 6'b000010, 0, 0, 0);
        step("sat_end", 6'b000000, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        step("ar_c0", 6'b111111, 0, 0, 1, 0, 6'b111111, 6'b000000, 0, 0, 0);
        step("ar_c1", 6'b111111, 0, 0, 0, 0, 6'b111111, 6'b000000, 1, 0, 0);
        step("ar_c2", 6'b111111, 0, 0, 0, 0, 6'b111111, 6'b000000, 1, 0, 0);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (a_stall !== 6'b0) begin n_bad++; $display("FAIL ar_stall: got %b expected 000000", a_stall); end
        n_cmp++; if (a_bubble !== 6'b0) begin n_bad++; $display("FAIL ar_bubble: got %b expected 000000", a_bubble); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL ar_busy: got %b expected 0", a_busy); end
        n_cmp++; if (a_sc !== 32'd0) begin n_bad++; $display("FAIL ar_stall_cycles: got %0d expected 0", a_sc); end
        n_cmp++; if (a_fc !== 32'd0) begin n_bad++; $display("FAIL ar_flush_count: got %0d expected 0", a_fc); end
        @(negedge clk);
        drive('0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        exp_sc = 0; exp_fc = 0;
        step("ar_rel0", 6'b000000, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0);
        step("ar_rel1", 6'b000000, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0);
        step("ar_go",   6'b000000, 0, 0, 1, 0, 6'b001111, 6'b010000, 0, 0, 0);
        step("ar_wait", 6'b000000, 0, 0, 0, 0, 6'b001111, 6'b010000, 1, 0, 0);
        step("ar_done", 6'b000000, 0, 0, 0, 1, 6'b000000, 6'b000000, 1, 0, 0);
        step("ar_idle", 6'b000000, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        use_b = 1'b0;
        exp_sc = 0; exp_fc = 0; cnt_max = 32'hFFFF_FFFF;
        drive('0, 1'b0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_prefix();
        test_mc_done();
        test_flush();
        test_timeout();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
